// File: rtl/cdc_arb_pkg.sv
// Shared types and helpers for the CDC send-port round-robin arbiter.
// Optional feature macro used by the arbiter: CDC_ARB_TIMEOUT_EN.
package cdc_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    localparam int DEFAULT_ID_WIDTH   = 2;
    localparam int DEFAULT_WORD_WIDTH = 32;
    localparam int SYNC_WIDTH         = DEFAULT_ID_WIDTH + DEFAULT_WORD_WIDTH;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/cdc_arb_rr_select.sv
// Combinational round-robin winner search starting just above the last grant.
// Part of cdc_send_arbiter; unaffected by CDC_ARB_TIMEOUT_EN.
module cdc_arb_rr_select
    import cdc_arb_pkg::*;
#(
    parameter int REQUESTER_COUNT = 4,
    parameter int IDX_WIDTH       = 2
) (
    input  logic [REQUESTER_COUNT-1:0] req_valid,
    input  logic [IDX_WIDTH-1:0]       last_grant,
    output logic [REQUESTER_COUNT-1:0] grant_onehot,
    output logic [IDX_WIDTH-1:0]       grant_index,
    output logic                       any_grant
);

    // The modulo keeps a non power-of-two count wrapping from N-1 straight to 0.
    always_comb begin
        grant_onehot = '0;
        grant_index  = '0;
        any_grant    = 1'b0;
        for (int k = 1; k <= REQUESTER_COUNT; k++) begin
            logic [IDX_WIDTH-1:0] w_idx;
            w_idx = IDX_WIDTH'((int'(last_grant) + k) % REQUESTER_COUNT);
            if (!any_grant && req_valid[w_idx]) begin
                any_grant           = 1'b1;
                grant_index         = w_idx;
                grant_onehot[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdc_send_arbiter.sv
// Round-robin arbiter sharing one CDC synchronizer sending port among ready/valid requesters.
// Define CDC_ARB_TIMEOUT_EN to add the sticky stall_timeout flag and its stall counter.
module cdc_send_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int REQUESTER_COUNT = 4,
    parameter int WORD_WIDTH      = DEFAULT_WORD_WIDTH,
    parameter int ID_WIDTH        = DEFAULT_ID_WIDTH
`ifdef CDC_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES  = 1024
`endif
) (
    input  logic                                  clock,
    input  logic                                  clear_n,
    input  logic [REQUESTER_COUNT-1:0]            req_valid,
    output logic [REQUESTER_COUNT-1:0]            req_ready,
    input  logic [REQUESTER_COUNT*WORD_WIDTH-1:0] req_data,
    output logic                                  sync_valid,
    input  logic                                  sync_ready,
    output logic [ID_WIDTH+WORD_WIDTH-1:0]        sync_data
`ifdef CDC_ARB_TIMEOUT_EN
    ,
    output logic                                  stall_timeout
`endif
);

    localparam int IDX_WIDTH = (clog2(REQUESTER_COUNT) < 1) ? 1 : clog2(REQUESTER_COUNT);

    arb_state_t                        r_state;
    arb_state_t                        w_next_state;
    logic [IDX_WIDTH-1:0]              r_last_grant;
    logic [ID_WIDTH+WORD_WIDTH-1:0]    r_sync_data;
    logic [REQUESTER_COUNT-1:0]        w_grant_onehot;
    logic [IDX_WIDTH-1:0]              w_grant_index;
    logic                              w_any_grant;
    logic                              w_capture;
    logic [WORD_WIDTH-1:0]             w_win_data;

    cdc_arb_rr_select #(
        .REQUESTER_COUNT (REQUESTER_COUNT),
        .IDX_WIDTH       (IDX_WIDTH)
    ) u_rr_select (
        .req_valid    (req_valid),
        .last_grant   (r_last_grant),
        .grant_onehot (w_grant_onehot),
        .grant_index  (w_grant_index),
        .any_grant    (w_any_grant)
    );

    always_comb begin
        w_win_data = '0;
        for (int i = 0; i < REQUESTER_COUNT; i++) begin
            if (w_grant_onehot[i]) begin
                w_win_data = req_data[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    // Grant and capture share one edge; clear_n gating keeps req_ready low during reset.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        req_ready    = '0;
        sync_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (clear_n) begin
                    req_ready = w_grant_onehot;
                end
                if (w_any_grant) begin
                    w_capture    = 1'b1;
                    w_next_state = OFFER;
                end
            end
            OFFER: begin
                sync_valid = 1'b1;
                if (sync_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_state      <= IDLE;
            r_last_grant <= IDX_WIDTH'(REQUESTER_COUNT - 1);
            r_sync_data  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_capture) begin
                r_last_grant <= w_grant_index;
                r_sync_data  <= {ID_WIDTH'(w_grant_index), w_win_data};
            end
        end
    end

    assign sync_data = r_sync_data;

`ifdef CDC_ARB_TIMEOUT_EN
    localparam int CNT_WIDTH = clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_WIDTH-1:0] r_stall_count;
    logic                 r_stall_timeout;

    // Counter saturates at the limit; the flag is sticky and never drops the held word.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_stall_count   <= '0;
            r_stall_timeout <= 1'b0;
        end else if (w_capture) begin
            r_stall_count <= '0;
        end else if ((r_state == OFFER) && !sync_ready &&
                     (r_stall_count != CNT_WIDTH'(TIMEOUT_CYCLES))) begin
            r_stall_count <= r_stall_count + 1'b1;
            if (r_stall_count == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                r_stall_timeout <= 1'b1;
            end
        end
    end

    assign stall_timeout = r_stall_timeout;
`endif

endmodule
